// File: rtl/sd_pkg.sv
// Shared sigma-delta constants and sizing helpers used by the modulator and the
// sinc3 decimator.
package sd_pkg;

  localparam int DEF_LOG2R = 6;
  localparam int DEF_BW    = 16;

  localparam int LOG2R_MIN = 2;
  localparam int LOG2R_MAX = 10;

  // Number of decimation events swallowed before the comb chain holds real data.
  localparam int WARM_EVENTS = 3;

  function automatic int cic_width(input int log2r);
    return 3 * log2r + 2;
  endfunction

  function automatic int out_shift(input int log2r, input int bw);
    return 3 * log2r + 1 - bw;
  endfunction

  function automatic longint sat_hi(input int bw);
    return (longint'(1) << (bw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int bw);
    return -(longint'(1) << (bw - 1));
  endfunction

  localparam longint DEF_SAT_HI = sat_hi(DEF_BW);
  localparam longint DEF_SAT_LO = sat_lo(DEF_BW);

endpackage

// File: rtl/cic_comb.sv
// One CIC comb stage: y = x - x_delayed, where the delay register advances only
// on enabled (decimation) cycles.
module cic_comb
  import sd_pkg::*;
#(
  parameter int W = cic_width(DEF_LOG2R)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);

  logic signed [W-1:0] dly_q;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its neighbours, which is what makes the chain pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
    end else if (en_i) begin
      dly_q <= x_i;
    end
  end

  assign y_o = x_i - dly_q;

endmodule

// File: rtl/sinc3_decim.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, signed PCM out every
// R = 2**LOG2R clocks, with a three-event warm-up before dout_valid is raised.
module sinc3_decim
  import sd_pkg::*;
#(
  parameter int LOG2R = DEF_LOG2R,
  parameter int BW    = DEF_BW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bs_in,
  output logic signed [BW-1:0] dout,
  output logic                 dout_valid
);

  localparam int W = cic_width(LOG2R);
  localparam int S = out_shift(LOG2R, BW);

  localparam logic signed [W-1:0] SAT_HI    = W'(sat_hi(BW));
  localparam logic signed [W-1:0] SAT_LO    = W'(sat_lo(BW));
  localparam logic        [1:0]   WARM_DONE = 2'(WARM_EVENTS);

  logic signed [W-1:0] x_ext;
  logic signed [W-1:0] int1_q, int1_d;
  logic signed [W-1:0] int2_q, int2_d;
  logic signed [W-1:0] int3_q, int3_d;
  logic [LOG2R-1:0]    cnt_q, cnt_d;
  logic [1:0]          warm_q, warm_d;
  logic signed [BW-1:0] dout_q, dout_d;
  logic                valid_q, valid_d;

  logic                dec_evt;
  logic signed [W-1:0] c1, c2, c3;
  logic signed [W-1:0] scaled;
  logic signed [BW-1:0] sat_val;

  // +1 is 0...01 and -1 is 1...11, so only the upper bits depend on bs_in.
  assign x_ext   = {{(W-1){~bs_in}}, 1'b1};
  assign dec_evt = &cnt_q;

  // Integrators wrap modulo 2**W on purpose; the combs undo the wrap exactly.
  always_comb begin
    int1_d = int1_q + x_ext;
    int2_d = int2_q + int1_q;
    int3_d = int3_q + int2_q;
    cnt_d  = cnt_q + LOG2R'(1);
  end

  cic_comb #(.W(W)) u_comb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (dec_evt),
    .x_i   (int3_q),
    .y_o   (c1)
  );

  cic_comb #(.W(W)) u_comb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (dec_evt),
    .x_i   (c1),
    .y_o   (c2)
  );

  cic_comb #(.W(W)) u_comb3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (dec_evt),
    .x_i   (c2),
    .y_o   (c3)
  );

  assign scaled = c3 >>> S;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sat_val = scaled[BW-1:0];
    if (scaled > SAT_HI) begin
      sat_val = SAT_HI[BW-1:0];
    end else if (scaled < SAT_LO) begin
      sat_val = SAT_LO[BW-1:0];
    end
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    warm_d  = warm_q;
    if (dec_evt) begin
      dout_d  = sat_val;
      valid_d = (warm_q == WARM_DONE);
      if (warm_q != WARM_DONE) begin
        warm_d = warm_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_q  <= '0;
      int2_q  <= '0;
      int3_q  <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      int3_q  <= int3_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_sinc3_decim.sv
// Scoreboard bench for sinc3_decim: expected samples come from a direct
// convolution of the +/-1 history with the sinc3 impulse response.
module tb_sinc3_decim;

  localparam int LOG2R   = 6;
  localparam int R       = 1 << LOG2R;
  localparam int BW      = 16;
  localparam int SHIFT   = 3 * LOG2R + 1 - BW;
  localparam longint HI  = 32767;
  localparam longint LO  = -32768;
  localparam int W_LOG2R = 10;
  localparam int W_R     = 1 << W_LOG2R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bs_in = 1'b0;
  logic signed [BW-1:0] dout;
  logic dout_valid;

  logic rst_w_n = 1'b0;
  logic bs_w = 1'b1;
  logic signed [BW-1:0] dout_w;
  logic valid_w;

  sinc3_decim #(.LOG2R(LOG2R), .BW(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bs_in      (bs_in),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  sinc3_decim #(.LOG2R(W_LOG2R), .BW(BW)) dut_w (
    .clk        (clk),
    .rst_n      (rst_w_n),
    .bs_in      (bs_w),
    .dout       (dout_w),
    .dout_valid (valid_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int     edge_n;
    longint val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;

  int xs [0:32767];
  int e_n = 0;
  int edge_cnt;
  int w_edge;
  int wide_valid_cnt = 0;

  function automatic longint tri2(input longint m);
    return (m < 2) ? 64'sd0 : m * (m - 1) / 2;
  endfunction

  // Comb output at edge e: the +/-1 history convolved with the sinc3 kernel.
  function automatic longint model_c3(input int e);
    longint acc = 0;
    int lo = (e - 3 * R - 2 > 1) ? e - 3 * R - 2 : 1;
    for (int i = lo; i <= e; i++) begin
      longint m = e - i;
      acc += xs[i] * (tri2(m - 1) - 3 * tri2(m - 1 - R)
                      + 3 * tri2(m - 1 - 2 * R) - tri2(m - 1 - 3 * R));
    end
    return acc;
  endfunction

  function automatic longint model_out(input int e);
    longint s = model_c3(e) >>> SHIFT;
    if (s > HI) s = HI;
    if (s < LO) s = LO;
    return s;
  endfunction

  function automatic bit rand_bit(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic drive_bit(input bit b);
    exp_t it;
    @(negedge clk);
    e_n++;
    xs[e_n] = b ? 1 : -1;
    bs_in = b;
    if ((e_n % R) == 0 && (e_n / R) >= 4) begin
      it.edge_n = e_n;
      it.val    = model_out(e_n);
      sb.push_back(it);
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear_dout", dout, 0);
    check("async_clear_valid", dout_valid, 0);
    repeat (ncyc) begin
      @(negedge clk);
      bs_in = 1'($urandom_range(0, 1));
      check("reset_hold_dout", dout, 0);
      check("reset_hold_valid", dout_valid, 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    e_n = 0;
    sb.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(posedge clk or negedge rst_w_n) begin
    if (!rst_w_n) w_edge <= 0;
    else          w_edge <= w_edge + 1;
  end

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_item = sb.pop_front();
        check("dout_sample", dout, mon_item.val);
        check("valid_edge", edge_cnt, mon_item.edge_n);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_w_n && valid_w) begin
      wide_valid_cnt++;
      check("wrap_dout", dout_w, HI);
      check("wrap_valid_edge", ((w_edge % W_R) == 0 && w_edge >= 4 * W_R), 1);
    end
  end

  initial begin
    int pcts [5] = '{50, 80, 20, 95, 5};

    repeat (10) begin
      @(negedge clk);
      bs_in = 1'($urandom_range(0, 1));
      check("reset_hold_dout", dout, 0);
      check("reset_hold_valid", dout_valid, 0);
      check("wrap_reset_dout", dout_w, 0);
    end
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    rst_w_n = 1'b1;
    e_n     = 0;

    repeat (8 * R) drive_bit(1'b1);
    repeat (8 * R) drive_bit(1'b0);
    for (int i = 0; i < 8 * R; i++) drive_bit((i % 2) == 0);

    do_reset(3);
    repeat (2 * R + 17) drive_bit(1'b1);
    do_reset(3);

    foreach (pcts[k]) begin
      repeat (12 * R) drive_bit(rand_bit(pcts[k]));
    end
    while (w_edge < 20 * W_R + 64 && e_n < 32000) begin
      drive_bit(rand_bit(50));
    end

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drain", sb.size(), 0);
    check("wrap_valid_count", wide_valid_cnt, (w_edge / W_R) - 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
